fft_note_classifier: RTL and testbench
======================================

Name: fft_note_classifier

Overview:
- Parametrised successor to the fixed two-way hi/lo note detector.
- Consumes the FFT magnitude stream directly; no intermediate BRAM is needed.
- Finds the peak bin per frame and maps it onto NUM_BANDS runtime-programmable bands.
- Debounces across frames, then reports a one-hot note followed by a frame-counted lockout.

Parameters:
MAG_W, 24, magnitude bus width
IDX_W, 12, bin index width
NUM_BANDS, 4, number of output bands (>=2)
BIN_LO, 1, lowest bin searched (skips DC)
BIN_HI, 1023, highest bin searched
HOLD_FRAMES, 45, consecutive identical frames required to report (>=1)
LOCKOUT_FRAMES, 60, frames ignored after a report (>=1)

Ports:
clk_104mhz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mag_tdata  in  MAG_W  FFT magnitude
mag_tuser  in  IDX_W  bin index of current beat
mag_tvalid  in  1  beat valid (no backpressure; sink always accepts)
mag_tlast  in  1  last beat of frame
mag_floor  in  MAG_W  minimum peak magnitude treated as a note
band_edge  in  (NUM_BANDS-1)*IDX_W  packed ascending edges; edge k in bits [k*IDX_W +: IDX_W]
note_pulse  out  NUM_BANDS  one-hot, one cycle at report
note_level  out  NUM_BANDS  one-hot, held through lockout
busy  out  1  high in REPORT or LOCKOUT

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state TRACK; hold_cnt 0; last_cls NONE.
  - Peak accumulators cleared.
- Peak search, on each beat with mag_tvalid=1 and BIN_LO<=mag_tuser<=BIN_HI:
  - If mag_tdata > best_mag (strict, so the lowest index wins ties), update best_mag and best_idx.
  - Beats with mag_tvalid=0 are ignored, including any tlast they carry.
- Frame end, on a beat with mag_tvalid&mag_tlast:
  - That beat is included in the comparison.
  - Next cycle, frame_done pulses with the result registered.
  - Accumulators clear in the same cycle, so a back-to-back next-frame beat starts fresh.
  - A frame with no in-range beat gives best_mag=0.
- Classification, registered with frame_done:
  - cls = NONE if best_mag < mag_floor.
  - Otherwise cls = number of edges k with best_idx >= edge[k], range 0..NUM_BANDS-1.
  - Non-monotone edges follow the same count formula; no error is flagged.
- FSM, TRACK:
  - On frame_done with cls=NONE: hold_cnt 0.
  - On frame_done with cls==last_cls: hold_cnt+1.
  - On frame_done otherwise: hold_cnt 1.
  - last_cls updates to cls on every frame_done.
  - When the updated hold_cnt == HOLD_FRAMES, go to REPORT.
- FSM, REPORT (exactly 1 cycle):
  - note_pulse[last_cls]=1 and note_level latched to the same one-hot.
  - lock_cnt 0; go to LOCKOUT.
- FSM, LOCKOUT:
  - Each frame_done increments lock_cnt; stream results are otherwise ignored.
  - When lock_cnt reaches LOCKOUT_FRAMES: note_level 0, hold_cnt 0, last_cls NONE, go to TRACK.
  - A frame_done in that same exit cycle is not classified.
- Latency:
  - Last beat to frame_done: 1 cycle.
  - frame_done to note_pulse: 1 cycle (the REPORT cycle follows the qualifying frame_done).
- Counter widths: $clog2 of (HOLD_FRAMES+1) and (LOCKOUT_FRAMES+1); counters never wrap.
- Reset mid-frame: the partial frame is discarded. After release the first tlast yields a result from only the beats seen since release.

Optional Feature:
FFT_CLASS_PEAK_OUT_EN:
- Defined: adds outputs dbg_peak_idx [IDX_W], dbg_peak_mag [MAG_W] and dbg_peak_valid.
  - Peak idx/mag are registered per frame and held until the next frame_done.
  - dbg_peak_valid is the frame_done pulse.
  - All three reset to 0.
- Undefined: these ports are absent and the logic is removed; classifier behaviour is identical.

Decomposition:
- Package fft_class_pkg:
  - state enum {TRACK, REPORT, LOCKOUT}.
  - CLS_NONE localparam, encoded as NUM_BANDS in a $clog2(NUM_BANDS+1)-bit class type.
  - Function edge_count() returning the band from an index and the packed edges.
- Sub-module fft_peak_search:
  - Contains the stream accumulators and range gate.
  - Outputs frame_done, best_idx and best_mag.
  - Instantiated once.

Test Plan:
- Edges {0x20,0x45,0x100}, floor 100; 45 frames with peak bin 0x50 mag 500 -> note_pulse=4'b0100 for one cycle, 1 cycle after the 45th frame_done; note_level=0100 and busy=1 for the next 60 frames.
- Alternate peak bins 0x10/0x50 every frame for 100 frames -> no note_pulse; hold_cnt never exceeds 1.
- Peak mag 99 (< floor 100) for 50 frames -> no report; then 45 frames at mag 100 -> report.
- Tie: bins 0x30 and 0x60 both mag 800 -> band chosen from 0x30 (band 1); DC bin 0 mag 9999 is ignored; tlast with tvalid=0 does not end the frame.
- During lockout, feed a new band for 30 frames -> no pulse; the lockout ends exactly at frame 60, note_level clears, and 45 fresh frames are needed to re-report.
- Assert rst_n low mid-frame and mid-lockout -> outputs 0 immediately (async); the partial post-release frame is classified from only the beats after release.

Source files
------------

// File: rtl/fft_class_pkg.sv
// Shared types and helpers for the FFT note classifier: FSM states, class
// encoding and the band-edge counting function.
package fft_class_pkg;

  localparam int unsigned DEF_MAG_W     = 24;
  localparam int unsigned DEF_IDX_W     = 12;
  localparam int unsigned DEF_NUM_BANDS = 4;

  // Class type for the default band count; NONE sits one past the last band.
  localparam int unsigned DEF_CLS_W = $clog2(DEF_NUM_BANDS + 1);
  typedef logic [DEF_CLS_W-1:0] cls_t;
  localparam cls_t CLS_NONE = cls_t'(DEF_NUM_BANDS);

  typedef enum logic [1:0] {
    ST_TRACK   = 2'd0,
    ST_REPORT  = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  // Widest configuration edge_count() can serve; callers zero-extend into it.
  localparam int unsigned MAX_BANDS  = 16;
  localparam int unsigned MAX_IDX_W  = 16;
  localparam int unsigned MAX_CLS_W  = $clog2(MAX_BANDS + 1);
  localparam int unsigned EDGE_BUS_W = (MAX_BANDS - 1) * MAX_IDX_W;

  // Band = number of active edges at or below idx; edge order is not checked.
  function automatic logic [MAX_CLS_W-1:0] edge_count(
    input logic [MAX_IDX_W-1:0]  idx,
    input logic [EDGE_BUS_W-1:0] edges,
    input int unsigned           num_edges
  );
    logic [MAX_CLS_W-1:0] cnt;
    cnt = '0;
    for (int unsigned k = 0; k < MAX_BANDS - 1; k++) begin
      if ((k < num_edges) && (idx >= edges[k*MAX_IDX_W +: MAX_IDX_W])) begin
        cnt = cnt + MAX_CLS_W'(1);
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fft_peak_search.sv
// Per-frame peak search over an FFT magnitude stream with a bin-range gate;
// emits a one-cycle frame_done with the frame's best bin and magnitude.
module fft_peak_search #(
  parameter int unsigned MAG_W  = 24,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned BIN_LO = 1,
  parameter int unsigned BIN_HI = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W-1:0] mag_tdata,
  input  logic [IDX_W-1:0] mag_tuser,
  input  logic             mag_tvalid,
  input  logic             mag_tlast,
  output logic             frame_done,
  output logic [IDX_W-1:0] best_idx,
  output logic [MAG_W-1:0] best_mag
);

  logic [MAG_W-1:0] r_acc_mag;
  logic [IDX_W-1:0] r_acc_idx;
  logic             w_in_range;
  logic             w_take;
  logic             w_frame_end;
  logic [MAG_W-1:0] w_cand_mag;
  logic [IDX_W-1:0] w_cand_idx;

  // Strict compare keeps the first (lowest-bin) beat on equal magnitudes.
  assign w_in_range  = (mag_tuser >= IDX_W'(BIN_LO)) && (mag_tuser <= IDX_W'(BIN_HI));
  assign w_take      = mag_tvalid && w_in_range && (mag_tdata > r_acc_mag);
  assign w_frame_end = mag_tvalid && mag_tlast;
  assign w_cand_mag  = w_take ? mag_tdata : r_acc_mag;
  assign w_cand_idx  = w_take ? mag_tuser : r_acc_idx;

  // The closing beat is folded in, then the accumulators restart for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_mag  <= '0;
      r_acc_idx  <= '0;
      best_mag   <= '0;
      best_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (w_frame_end) begin
        best_mag  <= w_cand_mag;
        best_idx  <= w_cand_idx;
        r_acc_mag <= '0;
        r_acc_idx <= '0;
      end else begin
        r_acc_mag <= w_cand_mag;
        r_acc_idx <= w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/fft_note_classifier.sv
// Classifies each FFT frame's peak bin into NUM_BANDS programmable bands, debounces
// across frames and reports a one-hot note followed by a frame-counted lockout.
// Optional peak debug outputs are enabled with FFT_CLASS_PEAK_OUT_EN.
module fft_note_classifier
  import fft_class_pkg::*;
#(
  parameter int unsigned MAG_W          = 24,
  parameter int unsigned IDX_W          = 12,
  parameter int unsigned NUM_BANDS      = 4,
  parameter int unsigned BIN_LO         = 1,
  parameter int unsigned BIN_HI         = 1023,
  parameter int unsigned HOLD_FRAMES    = 45,
  parameter int unsigned LOCKOUT_FRAMES = 60
) (
  input  logic                           clk_104mhz,
  input  logic                           rst_n,
  input  logic [MAG_W-1:0]               mag_tdata,
  input  logic [IDX_W-1:0]               mag_tuser,
  input  logic                           mag_tvalid,
  input  logic                           mag_tlast,
  input  logic [MAG_W-1:0]               mag_floor,
  input  logic [(NUM_BANDS-1)*IDX_W-1:0] band_edge,
  output logic [NUM_BANDS-1:0]           note_pulse,
  output logic [NUM_BANDS-1:0]           note_level,
  output logic                           busy
`ifdef FFT_CLASS_PEAK_OUT_EN
  ,
  output logic [IDX_W-1:0]               dbg_peak_idx,
  output logic [MAG_W-1:0]               dbg_peak_mag,
  output logic                           dbg_peak_valid
`endif
);

  localparam int unsigned CLS_W  = $clog2(NUM_BANDS + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_FRAMES + 1);
  localparam logic [CLS_W-1:0] L_CLS_NONE = CLS_W'(NUM_BANDS);

  logic                  w_frame_done;
  logic [IDX_W-1:0]      w_best_idx;
  logic [MAG_W-1:0]      w_best_mag;
  logic [EDGE_BUS_W-1:0] w_edges_max;
  logic [MAX_CLS_W-1:0]  w_band_raw;
  logic [CLS_W-1:0]      w_cls;
  logic [NUM_BANDS-1:0]  w_onehot;

  state_t                r_state,      w_state_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt,   w_hold_nxt;
  logic [LOCK_W-1:0]     r_lock_cnt,   w_lock_nxt;
  logic [CLS_W-1:0]      r_last_cls,   w_last_cls_nxt;
  logic [NUM_BANDS-1:0]  r_note_pulse, w_pulse_nxt;
  logic [NUM_BANDS-1:0]  r_note_level, w_level_nxt;
  logic                  r_busy,       w_busy_nxt;

  fft_peak_search #(
    .MAG_W  (MAG_W),
    .IDX_W  (IDX_W),
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI)
  ) u_peak (
    .clk        (clk_104mhz),
    .rst_n      (rst_n),
    .mag_tdata  (mag_tdata),
    .mag_tuser  (mag_tuser),
    .mag_tvalid (mag_tvalid),
    .mag_tlast  (mag_tlast),
    .frame_done (w_frame_done),
    .best_idx   (w_best_idx),
    .best_mag   (w_best_mag)
  );

  // Widen the packed edges into the package's fixed-size edge bus.
  always_comb begin
    w_edges_max = '0;
    for (int unsigned k = 0; k < NUM_BANDS - 1; k++) begin
      w_edges_max[k*MAX_IDX_W +: MAX_IDX_W] = MAX_IDX_W'(band_edge[k*IDX_W +: IDX_W]);
    end
  end

  assign w_band_raw = edge_count(MAX_IDX_W'(w_best_idx), w_edges_max, NUM_BANDS - 1);
  assign w_cls      = (w_best_mag < mag_floor) ? L_CLS_NONE : CLS_W'(w_band_raw);
  assign w_onehot   = NUM_BANDS'(1) << w_cls;

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_TRACK;
      r_hold_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_last_cls   <= L_CLS_NONE;
      r_note_pulse <= '0;
      r_note_level <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_lock_cnt   <= w_lock_nxt;
      r_last_cls   <= w_last_cls_nxt;
      r_note_pulse <= w_pulse_nxt;
      r_note_level <= w_level_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Outputs are loaded on the transition so the pulse lines up with the REPORT cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold_cnt;
    w_lock_nxt     = r_lock_cnt;
    w_last_cls_nxt = r_last_cls;
    w_pulse_nxt    = '0;
    w_level_nxt    = r_note_level;
    unique case (r_state)
      ST_TRACK: begin
        if (w_frame_done) begin
          if (w_cls == L_CLS_NONE) begin
            w_hold_nxt = '0;
          end else if (w_cls == r_last_cls) begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end else begin
            w_hold_nxt = HOLD_W'(1);
          end
          w_last_cls_nxt = w_cls;
          if (w_hold_nxt == HOLD_W'(HOLD_FRAMES)) begin
            w_state_nxt = ST_REPORT;
            w_pulse_nxt = w_onehot;
            w_level_nxt = w_onehot;
          end
        end
      end
      ST_REPORT: begin
        w_lock_nxt  = '0;
        w_state_nxt = ST_LOCKOUT;
      end
      ST_LOCKOUT: begin
        // The frame that completes the lockout is consumed here, never classified.
        if (w_frame_done) begin
          w_lock_nxt = r_lock_cnt + LOCK_W'(1);
          if (w_lock_nxt == LOCK_W'(LOCKOUT_FRAMES)) begin
            w_level_nxt    = '0;
            w_hold_nxt     = '0;
            w_last_cls_nxt = L_CLS_NONE;
            w_state_nxt    = ST_TRACK;
          end
        end
      end
      default: begin
        w_state_nxt = ST_TRACK;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_TRACK);
  end

  assign note_pulse = r_note_pulse;
  assign note_level = r_note_level;
  assign busy       = r_busy;

`ifdef FFT_CLASS_PEAK_OUT_EN
  assign dbg_peak_idx   = w_best_idx;
  assign dbg_peak_mag   = w_best_mag;
  assign dbg_peak_valid = w_frame_done;
`endif

endmodule

// File: tb/tb_fft_note_classifier.sv
// Self-checking bench for fft_note_classifier: directed and randomized frames
// scored against a frame-level reference model of the classifier.
module tb_fft_note_classifier;

  localparam int unsigned MAG_W  = 24;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned NB     = 4;
  localparam int unsigned BIN_LO = 1;
  localparam int unsigned BIN_HI = 1023;
  localparam int          HOLD   = 45;
  localparam int          LOCK   = 60;

  logic                    clk_104mhz = 1'b0;
  logic                    rst_n;
  logic [MAG_W-1:0]        mag_tdata;
  logic [IDX_W-1:0]        mag_tuser;
  logic                    mag_tvalid;
  logic                    mag_tlast;
  logic [MAG_W-1:0]        mag_floor;
  logic [(NB-1)*IDX_W-1:0] band_edge;
  logic [NB-1:0]           note_pulse;
  logic [NB-1:0]           note_level;
  logic                    busy;
`ifdef FFT_CLASS_PEAK_OUT_EN
  logic [IDX_W-1:0]        dbg_peak_idx;
  logic [MAG_W-1:0]        dbg_peak_mag;
  logic                    dbg_peak_valid;
`endif

  always #5 clk_104mhz = ~clk_104mhz;

  fft_note_classifier #(
    .MAG_W(MAG_W), .IDX_W(IDX_W), .NUM_BANDS(NB), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI),
    .HOLD_FRAMES(HOLD), .LOCKOUT_FRAMES(LOCK)
  ) dut (
    .clk_104mhz (clk_104mhz),
    .rst_n      (rst_n),
    .mag_tdata  (mag_tdata),
    .mag_tuser  (mag_tuser),
    .mag_tvalid (mag_tvalid),
    .mag_tlast  (mag_tlast),
    .mag_floor  (mag_floor),
    .band_edge  (band_edge),
    .note_pulse (note_pulse),
    .note_level (note_level),
    .busy       (busy)
`ifdef FFT_CLASS_PEAK_OUT_EN
    ,
    .dbg_peak_idx   (dbg_peak_idx),
    .dbg_peak_mag   (dbg_peak_mag),
    .dbg_peak_valid (dbg_peak_valid)
`endif
  );

  int n_tests;
  int n_fail;

  // Frame under construction: one entry per beat.
  int unsigned q_mag[$];
  int unsigned q_bin[$];
  bit          q_val[$];

  // Reference model state (frame granularity); -1 means no class / no note.
  int unsigned m_edge[NB-1];
  int unsigned m_floor;
  int          m_hold, m_last, m_lock, m_level;
  bit          m_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] oh(input int b);
    oh = '0;
    if (b >= 0) oh = NB'(1) << b;
  endfunction

  function automatic void model_reset();
    m_hold = 0; m_last = -1; m_lock = 0; m_level = -1; m_locked = 1'b0;
  endfunction

  task automatic set_edges(input int unsigned e0, input int unsigned e1, input int unsigned e2);
    m_edge[0] = e0; m_edge[1] = e1; m_edge[2] = e2;
    band_edge = {IDX_W'(e2), IDX_W'(e1), IDX_W'(e0)};
  endtask

  task automatic set_floor(input int unsigned f);
    m_floor = f;
    mag_floor = MAG_W'(f);
  endtask

  // Peak = max magnitude over valid in-range beats, lowest bin among equals; then band.
  function automatic int model_cls();
    int unsigned mx = 0;
    int unsigned idx = 0;
    int          band = 0;
    for (int i = 0; i < q_mag.size(); i++)
      if (q_val[i] && q_bin[i] >= BIN_LO && q_bin[i] <= BIN_HI && q_mag[i] > mx) mx = q_mag[i];
    if (mx > 0) begin
      idx = 32'hFFFF_FFFF;
      for (int i = 0; i < q_mag.size(); i++)
        if (q_val[i] && q_bin[i] >= BIN_LO && q_bin[i] <= BIN_HI && q_mag[i] == mx && q_bin[i] < idx)
          idx = q_bin[i];
    end
    if (mx < m_floor) return -1;
    for (int k = 0; k < NB - 1; k++) if (idx >= m_edge[k]) band++;
    return band;
  endfunction

  task automatic model_frame(input int cls, output int pb);
    pb = -1;
    if (m_locked) begin
      m_lock++;
      if (m_lock == LOCK) begin
        m_locked = 1'b0; m_level = -1; m_hold = 0; m_last = -1;
      end
    end else begin
      if (cls < 0) m_hold = 0;
      else if (cls == m_last) m_hold++;
      else m_hold = 1;
      m_last = cls;
      if (m_hold == HOLD) begin
        pb = cls; m_level = cls; m_locked = 1'b1; m_lock = 0;
      end
    end
  endtask

  task automatic push(input int unsigned mag, input int unsigned bin, input bit val);
    q_mag.push_back(mag); q_bin.push_back(bin); q_val.push_back(val);
  endtask

  task automatic drive_beat(input int unsigned mag, input int unsigned bin, input bit val, input bit last);
    mag_tdata  = MAG_W'(mag);
    mag_tuser  = IDX_W'(bin);
    mag_tvalid = val;
    mag_tlast  = last;
    @(posedge clk_104mhz); #1;
    mag_tvalid = 1'b0;
    mag_tlast  = 1'b0;
  endtask

  function automatic int unsigned below(input int unsigned m);
    return (m > 0) ? $urandom_range(0, m - 1) : 0;
  endfunction

  // Randomised frame whose in-range peak is (pbin, pmag); DC, invalid and out-of-range beats carry decoys.
  task automatic build_std(input int unsigned pbin, input int unsigned pmag);
    bit oor_first, peak_last;
    q_mag.delete(); q_bin.delete(); q_val.delete();
    oor_first = 1'($urandom_range(0, 1));
    peak_last = 1'($urandom_range(0, 1));
    push($urandom_range(0, 20000), 0, 1'b1);
    if (pbin > 2) push(below(pmag), $urandom_range(1, pbin - 1), 1'b1);
    push($urandom_range(0, 24'hFFFFFF), $urandom_range(0, 4095), 1'b0);
    if (oor_first) push($urandom_range(0, 24'hFFFFFF), $urandom_range(1024, 4095), 1'b1);
    push(pmag, pbin, 1'b1);
    if (!peak_last && pbin < 1022) push(below(pmag), $urandom_range(pbin + 1, 1023), 1'b1);
    if (!oor_first && !peak_last) push($urandom_range(0, 24'hFFFFFF), $urandom_range(1024, 4095), 1'b1);
  endtask

  task automatic build_tie();
    q_mag.delete(); q_bin.delete(); q_val.delete();
    push(9999, 0, 1'b1);
    push(800, 'h30, 1'b1);
    push(12345, 'h40, 1'b0);
    push(800, 'h60, 1'b1);
    push(5, 'h70, 1'b1);
  endtask

  // Drives the queued frame (invalid beats also carry tlast) and checks output timing.
  task automatic run_frame();
    int cls, pb, n;
    cls = model_cls();
    n = q_mag.size();
    for (int i = 0; i < n; i++) drive_beat(q_mag[i], q_bin[i], q_val[i], (i == n - 1) || !q_val[i]);
    check("pulse_at_frame_done", 32'(note_pulse), 32'(0));
    model_frame(cls, pb);
    @(posedge clk_104mhz); #1;
    check("pulse_report", 32'(note_pulse), 32'(oh(pb)));
    check("level", 32'(note_level), 32'(oh(m_level)));
    check("busy", 32'(busy), 32'(m_locked));
    @(posedge clk_104mhz); #1;
    check("pulse_one_cycle", 32'(note_pulse), 32'(0));
    @(posedge clk_104mhz); #1;
  endtask

  task automatic frames(input int cnt, input int unsigned pbin, input int unsigned pmag);
    for (int i = 0; i < cnt; i++) begin
      build_std(pbin, pmag);
      run_frame();
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    mag_tdata = '0; mag_tuser = '0; mag_tvalid = 1'b0; mag_tlast = 1'b0;
    set_edges('h20, 'h45, 'h100);
    set_floor(100);
    model_reset();
    repeat (3) @(posedge clk_104mhz);
    #1;
    check("rst_pulse", 32'(note_pulse), 32'(0));
    check("rst_level", 32'(note_level), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    @(posedge clk_104mhz); #1;

    // Basic report into band 2, then a different band during lockout.
    frames(45, 'h50, 500);
    check("t1_level", 32'(note_level), 32'(4'b0100));
    check("t1_busy", 32'(busy), 32'(1));
    frames(30, 'h10, 500);
    check("t1_mid_lock_level", 32'(note_level), 32'(4'b0100));
    frames(30, 'h10, 500);
    check("t1_exit_level", 32'(note_level), 32'(0));
    check("t1_exit_busy", 32'(busy), 32'(0));
    frames(44, 'h10, 500);
    check("t1_rearm_level", 32'(note_level), 32'(0));
    frames(1, 'h10, 500);
    check("t1_rereport_level", 32'(note_level), 32'(4'b0001));
    frames(60, 'h50, 500);

    // Alternating bands never debounce.
    for (int i = 0; i < 100; i++) frames(1, (i % 2 == 0) ? 'h10 : 'h50, 500);
    check("t2_level", 32'(note_level), 32'(0));

    // Floor boundary: 99 rejected, 100 accepted.
    frames(50, 'h50, 99);
    check("t3_below_floor", 32'(busy), 32'(0));
    frames(45, 'h50, 100);
    check("t3_at_floor", 32'(note_level), 32'(4'b0100));
    frames(60, 'h50, 100);

    // Tie resolves to the lower bin; DC and invalid tlast ignored.
    for (int i = 0; i < 45; i++) begin build_tie(); run_frame(); end
    check("t4_tie_level", 32'(note_level), 32'(4'b0010));
    for (int i = 0; i < 60; i++) begin build_tie(); run_frame(); end

    // Random edges (non-monotone allowed), floors and run lengths.
    for (int r = 0; r < 10; r++) begin
      int unsigned pb, pm, len;
      set_edges($urandom_range(0, 1100), $urandom_range(0, 1100), $urandom_range(0, 1100));
      set_floor($urandom_range(0, 1000));
      pb  = $urandom_range(1, 1023);
      pm  = $urandom_range(0, 2000);
      len = $urandom_range(1, 70);
      frames(int'(len), pb, pm);
    end

    // Reset in the middle of a frame during lockout.
    set_edges('h20, 'h45, 'h100);
    set_floor(100);
    for (int i = 0; i < 200 && !m_locked; i++) frames(1, 'h50, 500);
    frames(5, 'h50, 500);
    check("t6_pre_rst_busy", 32'(busy), 32'(1));
    drive_beat(900000, 'h50, 1'b1, 1'b0);
    drive_beat(900000, 'h60, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_pulse", 32'(note_pulse), 32'(0));
    check("t6_async_level", 32'(note_level), 32'(0));
    check("t6_async_busy", 32'(busy), 32'(0));
    model_reset();
    @(posedge clk_104mhz); @(posedge clk_104mhz);
    #3 rst_n = 1'b1;
    q_mag.delete(); q_bin.delete(); q_val.delete();
    push(300, 'h08, 1'b1);
    push(700, 'h10, 1'b1);
    push(50, 'h200, 1'b1);
    run_frame();
    frames(43, 'h10, 500);
    check("t6_no_early_report", 32'(note_level), 32'(0));
    frames(1, 'h10, 500);
    check("t6_post_rst_report", 32'(note_level), 32'(4'b0001));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
